pll_dyn_ctrl: RTL and testbench

Run-time controller for a Gowin rPLL operated with dynamic divider selection (DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true"). It holds a parametrised table of N_MODES divider settings and applies a requested mode by driving the PLL's IDSEL/FBDSEL/ODSEL pins, pulsing PLL RESET and qualifying LOCK. It retries on lock timeout and releases a downstream reset only after lock has been stable. It sits in the board top between the raw input clock domain (e.g. 27 MHz) and the PLL primitive wrapper.

---
 rtl/pll_ctrl_pkg.sv | 16 +
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_dyn_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pll_dyn_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types for the rPLL dynamic-divider controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_ctrl_pkg;

    localparam int SEL_W = 6;

    typedef enum logic [2:0] {
        PRST,
        WLOCK,
        STABLE,
        RUN,
        FAIL
    } pll_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a level signal arriving from another clock domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Gowin rPLL run-time controller: applies table divider modes, pulses RESET, qualifies LOCK, retries on timeout.
// Latency: outputs registered; pll_lock fall reaches locked/out_rst_n 3 edges later; lock qualified LOCK_STABLE_CYCLES+1 edges after lock_s rises.
// Backpressure: mode_req_ready is high only in RUN and FAIL; requests wait while the PLL is being reset or qualified.
module pll_dyn_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                       N_MODES             = 4,
    parameter logic [SEL_W*N_MODES-1:0] MODE_IDSEL          = {N_MODES{6'd1}},
    parameter logic [SEL_W*N_MODES-1:0] MODE_FBDSEL         = {N_MODES{6'd15}},
    parameter logic [SEL_W*N_MODES-1:0] MODE_ODSEL          = {N_MODES{6'd56}},
    parameter int                       DEFAULT_MODE        = 0,
    parameter int                       RESET_CYCLES        = 27,
    parameter int                       LOCK_STABLE_CYCLES  = 2700,
    parameter int                       LOCK_TIMEOUT_CYCLES = 270000,
    parameter int                       MAX_RETRIES         = 3,
    localparam int                      MW                  = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_req_valid,
    input  logic [MW-1:0]    mode_req,
    output logic             mode_req_ready,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    output logic             locked,
    output logic             out_rst_n,
    output logic [MW-1:0]    mode_cur,
    output logic             fail,
    output logic [7:0]       lock_loss_cnt
);

    localparam int CNT_MAX0 = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > LOCK_TIMEOUT_CYCLES) ? CNT_MAX0 : LOCK_TIMEOUT_CYCLES;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int RW       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int TW       = SEL_W * N_MODES;
    localparam int IW       = (TW > 1) ? $clog2(TW) : 1;

    pll_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] retries, retries_nxt;
    logic          lock_s;
    logic          accept;
    logic          loss_inc;
    logic [MW-1:0] mode_sel;
    logic [IW-1:0] sel_base;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign accept   = mode_req_valid && mode_req_ready;
    // Out-of-range requests are accepted but pinned to the last table entry.
    assign mode_sel = (int'(mode_req) >= N_MODES) ? MW'(N_MODES - 1) : mode_req;
    assign sel_base = IW'(mode_sel) * IW'(SEL_W);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        retries_nxt = retries;
        loss_inc    = 1'b0;
        case (state)
            PRST: begin
                if (cnt == CW'(RESET_CYCLES - 1)) begin
                    state_nxt = WLOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WLOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    cnt_nxt = '0;
                    if (retries < RW'(MAX_RETRIES)) begin
                        retries_nxt = retries + RW'(1);
                        state_nxt   = PRST;
                    end else begin
                        state_nxt = FAIL;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WLOCK;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    loss_inc    = 1'b1;
                    state_nxt   = PRST;
                    cnt_nxt     = '0;
                    retries_nxt = '0;
                end
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = PRST;
                cnt_nxt   = '0;
            end
        endcase
        // A request overrides whatever the lock logic decided this cycle.
        if (accept) begin
            state_nxt   = PRST;
            cnt_nxt     = '0;
            retries_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= PRST;
            cnt            <= '0;
            retries        <= '0;
            mode_cur       <= MW'(DEFAULT_MODE);
            pll_idsel      <= MODE_IDSEL[DEFAULT_MODE*SEL_W +: SEL_W];
            pll_fbdsel     <= MODE_FBDSEL[DEFAULT_MODE*SEL_W +: SEL_W];
            pll_odsel      <= MODE_ODSEL[DEFAULT_MODE*SEL_W +: SEL_W];
            pll_reset      <= 1'b1;
            locked         <= 1'b0;
            out_rst_n      <= 1'b0;
            fail           <= 1'b0;
            mode_req_ready <= 1'b0;
            lock_loss_cnt  <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            retries        <= retries_nxt;
            pll_reset      <= (state_nxt == PRST) || (state_nxt == FAIL);
            locked         <= (state_nxt == RUN);
            out_rst_n      <= (state_nxt == RUN);
            fail           <= (state_nxt == FAIL);
            mode_req_ready <= (state_nxt == RUN) || (state_nxt == FAIL);
            if (accept) begin
                mode_cur   <= mode_sel;
                pll_idsel  <= MODE_IDSEL[sel_base +: SEL_W];
                pll_fbdsel <= MODE_FBDSEL[sel_base +: SEL_W];
                pll_odsel  <= MODE_ODSEL[sel_base +: SEL_W];
            end
            if (loss_inc && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl with short reset/stable/timeout windows and a 3-entry mode table.
// Mode k table entries: IDSEL=10+k, FBDSEL=20+k, ODSEL=32+k.
module tb_pll_dyn_ctrl;

    logic       clk;
    logic       rst_n;
    logic       mode_req_valid;
    logic [1:0] mode_req;
    logic       mode_req_ready;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       locked;
    logic       out_rst_n;
    logic [1:0] mode_cur;
    logic       fail;
    logic [7:0] lock_loss_cnt;

    int vectors = 0;
    int errs    = 0;

    pll_dyn_ctrl #(
        .N_MODES             (3),
        .MODE_IDSEL          ({6'd12, 6'd11, 6'd10}),
        .MODE_FBDSEL         ({6'd22, 6'd21, 6'd20}),
        .MODE_ODSEL          ({6'd34, 6'd33, 6'd32}),
        .DEFAULT_MODE        (0),
        .RESET_CYCLES        (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode_req_valid (mode_req_valid),
        .mode_req       (mode_req),
        .mode_req_ready (mode_req_ready),
        .pll_lock       (pll_lock),
        .pll_reset      (pll_reset),
        .pll_idsel      (pll_idsel),
        .pll_fbdsel     (pll_fbdsel),
        .pll_odsel      (pll_odsel),
        .locked         (locked),
        .out_rst_n      (out_rst_n),
        .mode_cur       (mode_cur),
        .fail           (fail),
        .lock_loss_cnt  (lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] exp_sel(input int k);
        return {6'(10 + k), 6'(20 + k), 6'(32 + k)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until locked, or -1 if the budget expires.
    task automatic wait_lock(input int budget, output int cycles);
        cycles = 0;
        while (!locked && cycles < budget) begin
            step(1);
            cycles++;
        end
        if (!locked) cycles = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; pll_lock = 1'b0; mode_req_valid = 1'b0; mode_req = 2'd0;
        #2 rst_n = 1'b0;
        step(2);
        vectors++;
        if ({pll_reset, locked, out_rst_n, fail, mode_req_ready} !== 5'b10000) begin
            errs++; $display("FAIL reset.flags got %b want 10000", {pll_reset, locked, out_rst_n, fail, mode_req_ready});
        end
        vectors++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(0)) begin
            errs++; $display("FAIL reset.sel got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(0));
        end
        vectors++;
        if (mode_cur !== 2'd0 || lock_loss_cnt !== 8'd0) begin
            errs++; $display("FAIL reset.mode_cnt got %0d/%0d want 0/0", mode_cur, lock_loss_cnt);
        end
    endtask

    task automatic test_lock_acquire;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            vectors++;
            if (pll_reset !== (i < 4)) begin
                errs++; $display("FAIL acquire.pll_reset edge %0d got %b want %b", i, pll_reset, (i < 4));
            end
        end
        step(6);
        pll_lock = 1'b1;
        step(10);
        vectors++;
        if (locked !== 1'b0) begin
            errs++; $display("FAIL acquire.early_lock got %b want 0", locked);
        end
        step(1);
        vectors++;
        if ({locked, out_rst_n, mode_req_ready} !== 3'b111) begin
            errs++; $display("FAIL acquire.locked got %b want 111", {locked, out_rst_n, mode_req_ready});
        end
        vectors++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(0)) begin
            errs++; $display("FAIL acquire.sel got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(0));
        end
    endtask

    task automatic test_mode_req;
        mode_req_valid = 1'b1; mode_req = 2'd2;
        vectors++;
        if (mode_req_ready !== 1'b1) begin
            errs++; $display("FAIL mode_req.ready got %b want 1", mode_req_ready);
        end
        step(1);
        mode_req_valid = 1'b0;
        vectors++;
        if ({pll_reset, mode_req_ready, locked} !== 3'b100 || mode_cur !== 2'd2) begin
            errs++; $display("FAIL mode_req.accept got %b mode %0d want 100 mode 2", {pll_reset, mode_req_ready, locked}, mode_cur);
        end
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(2)) begin
                errs++; $display("FAIL mode_req.sel edge %0d got %h want %h", i, {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(2));
            end
            step(1);
            vectors++;
            if (pll_reset !== (i < 4)) begin
                errs++; $display("FAIL mode_req.pulse edge %0d got %b want %b", i, pll_reset, (i < 4));
            end
        end
        step(8);
        vectors++;
        if (locked !== 1'b0) begin
            errs++; $display("FAIL mode_req.early_lock got %b want 0", locked);
        end
        step(1);
        vectors++;
        if (locked !== 1'b1) begin
            errs++; $display("FAIL mode_req.relock got %b want 1", locked);
        end
    endtask

    task automatic test_lock_loss;
        int c;
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(1);
        vectors++;
        if (out_rst_n !== 1'b1) begin
            errs++; $display("FAIL loss.early got out_rst_n %b want 1", out_rst_n);
        end
        step(1);
        vectors++;
        if ({out_rst_n, locked, pll_reset} !== 3'b001 || lock_loss_cnt !== 8'd1) begin
            errs++; $display("FAIL loss.react got %b cnt %0d want 001 cnt 1", {out_rst_n, locked, pll_reset}, lock_loss_cnt);
        end
        wait_lock(100, c);
        vectors++;
        if (c !== 13) begin
            errs++; $display("FAIL loss.relock_cycles got %0d want 13", c);
        end
    endtask

    task automatic test_stable_glitch;
        logic seen;
        mode_req_valid = 1'b1; mode_req = 2'd2;
        step(1);
        mode_req_valid = 1'b0;
        vectors++;
        if (pll_reset !== 1'b1 || mode_cur !== 2'd2) begin
            errs++; $display("FAIL glitch.same_mode got reset %b mode %0d want 1 mode 2", pll_reset, mode_cur);
        end
        step(8);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        seen = 1'b0;
        for (int i = 10; i <= 19; i++) begin
            step(1);
            seen = seen | locked;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errs++; $display("FAIL glitch.pulse got locked %b want 0", seen);
        end
        step(1);
        vectors++;
        if (locked !== 1'b1) begin
            errs++; $display("FAIL glitch.restart got locked %b want 1", locked);
        end
    endtask

    task automatic test_timeout_fail;
        int  rises;
        int  c;
        logic prev;
        rises = 0;
        prev  = pll_reset;
        pll_lock = 1'b0;
        for (int i = 1; i <= 111; i++) begin
            step(1);
            if (pll_reset && !prev && !fail) rises++;
            prev = pll_reset;
            if (i == 110) begin
                vectors++;
                if (fail !== 1'b0) begin
                    errs++; $display("FAIL timeout.early_fail got %b want 0", fail);
                end
            end
        end
        vectors++;
        if ({fail, pll_reset, mode_req_ready, locked} !== 4'b1110) begin
            errs++; $display("FAIL timeout.fail_state got %b want 1110", {fail, pll_reset, mode_req_ready, locked});
        end
        vectors++;
        if (rises !== 3 || lock_loss_cnt !== 8'd2) begin
            errs++; $display("FAIL timeout.pulses got %0d cnt %0d want 3 cnt 2", rises, lock_loss_cnt);
        end
        mode_req_valid = 1'b1; mode_req = 2'd1;
        step(1);
        mode_req_valid = 1'b0;
        vectors++;
        if ({fail, pll_reset} !== 2'b01 || mode_cur !== 2'd1 || {pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(1)) begin
            errs++; $display("FAIL timeout.recover got %b mode %0d sel %h want 01 mode 1 sel %h",
                             {fail, pll_reset}, mode_cur, {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(1));
        end
        step(3);
        vectors++;
        if (pll_reset !== 1'b1) begin
            errs++; $display("FAIL timeout.pulse_hi got %b want 1", pll_reset);
        end
        step(1);
        vectors++;
        if (pll_reset !== 1'b0) begin
            errs++; $display("FAIL timeout.pulse_lo got %b want 0", pll_reset);
        end
        pll_lock = 1'b1;
        wait_lock(100, c);
        vectors++;
        if (c < 0 || fail !== 1'b0) begin
            errs++; $display("FAIL timeout.relock got cycles %0d fail %b want lock fail 0", c, fail);
        end
    endtask

    task automatic test_mid_reset;
        mode_req_valid = 1'b1; mode_req = 2'd3;
        step(1);
        mode_req_valid = 1'b0;
        vectors++;
        if (mode_cur !== 2'd2 || {pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(2)) begin
            errs++; $display("FAIL clamp.mode got %0d sel %h want 2 sel %h", mode_cur, {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(2));
        end
        step(7);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({pll_reset, locked, out_rst_n, fail, mode_req_ready} !== 5'b10000 || mode_cur !== 2'd0 || lock_loss_cnt !== 8'd0) begin
            errs++; $display("FAIL mid_reset.flags got %b mode %0d cnt %0d want 10000 mode 0 cnt 0",
                             {pll_reset, locked, out_rst_n, fail, mode_req_ready}, mode_cur, lock_loss_cnt);
        end
        vectors++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_sel(0)) begin
            errs++; $display("FAIL mid_reset.sel got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, exp_sel(0));
        end
    endtask

    task automatic test_saturation;
        int c;
        int timeouts;
        logic [7:0] want;
        timeouts = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_lock(100, c);
            if (c < 0) timeouts++;
            pll_lock = 1'b0;
            step(1);
            pll_lock = 1'b1;
            step(2);
            want = (i >= 254) ? 8'd255 : 8'(i + 1);
            if (i == 0 || i >= 253) begin
                vectors++;
                if (lock_loss_cnt !== want) begin
                    errs++; $display("FAIL saturate.cnt loss %0d got %0d want %0d", i + 1, lock_loss_cnt, want);
                end
            end
        end
        wait_lock(100, c);
        if (c < 0) timeouts++;
        vectors++;
        if (timeouts !== 0) begin
            errs++; $display("FAIL saturate.relock got %0d timeouts want 0", timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_mode_req();
        test_lock_loss();
        test_stable_glitch();
        test_timeout_fail();
        test_mid_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
